// File: rtl/dvp_pkg.sv
// Shared types for the synthetic DVP source: pattern codes, vertical FSM states
// and the fixed pixel levels used by the test images.
package dvp_pkg;

   typedef enum logic [1:0] {
      PAT_RAMP = 2'd0,
      PAT_BARS = 2'd1,
      PAT_BOX  = 2'd2,
      PAT_FLAT = 2'd3
   } pattern_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_VFRONT
   } state_t;

   localparam logic [7:0] BG_LEVEL  = 8'h20;
   localparam logic [7:0] BOX_LEVEL = 8'hF0;
   localparam int         NUM_BARS  = 8;
   localparam int         BAR_STEP  = 36;

endpackage

// File: rtl/dvp_pattern_pixel.sv
// Combinational pixel generator: maps (x, y) plus the latched pattern select,
// box position and flat level onto one 8-bit RAW value.
module dvp_pattern_pixel
   import dvp_pkg::*;
#(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int BOX_SIZE  = 64,
   parameter int XW        = 10,
   parameter int YW        = 9
) (
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  pattern_t      sel,
   input  logic [XW-1:0] box_x,
   input  logic [7:0]    flat,
   output logic [7:0]    pixel
);

   localparam int BOX_Y0 = (IMG_VDISP - BOX_SIZE) / 2;

   int   xi;
   int   yi;
   int   bxi;
   int   bar;
   logic in_box;

   always_comb begin
      xi     = int'(x);
      yi     = int'(y);
      bxi    = int'(box_x);
      bar    = (xi * NUM_BARS) / IMG_HDISP;
      in_box = (xi >= bxi) && (xi < bxi + BOX_SIZE) &&
               (yi >= BOX_Y0) && (yi < BOX_Y0 + BOX_SIZE);
      case (sel)
         PAT_RAMP: pixel = 8'(xi + yi);
         PAT_BARS: pixel = 8'(bar * BAR_STEP);
         PAT_BOX:  pixel = in_box ? BOX_LEVEL : BG_LEVEL;
         default:  pixel = flat;
      endcase
   end

endmodule

// File: rtl/dvp_pattern_source.sv
// Synthetic 8-bit RAW DVP camera: OV-style vsync/href timing with ramp, bar,
// moving-box and flat test images; frames are never truncated by enable.
module dvp_pattern_source
   import dvp_pkg::*;
#(
   parameter int IMG_HDISP   = 640,
   parameter int IMG_VDISP   = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   parameter int BOX_SIZE    = 64,
   parameter int BOX_STEP    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   input  logic [7:0] flat_level,
   output logic       cmos_vsync,
   output logic       cmos_href,
   output logic [7:0] cmos_data,
   output logic [7:0] frame_cnt,
   output logic       frame_busy
);

   localparam int H_TOTAL   = IMG_HDISP + H_BLANK;
   localparam int HW        = $clog2(H_TOTAL);
   localparam int V_MAX_A   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
   localparam int V_MAX_B   = (IMG_VDISP > V_FRONT) ? IMG_VDISP : V_FRONT;
   localparam int V_MAX     = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int VW        = (V_MAX > 1) ? $clog2(V_MAX) : 1;
   localparam int BOX_X_MAX = IMG_HDISP - BOX_SIZE;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

   state_t        state_q,     state_d;
   logic [HW-1:0] h_cnt_q,     h_cnt_d;
   logic [VW-1:0] v_cnt_q,     v_cnt_d;
   pattern_t      sel_q,       sel_d;
   logic [HW-1:0] box_x_q,     box_x_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          vsync_q,     vsync_d;
   logic          href_q,      href_d;
   logic [7:0]    data_q,      data_d;
   logic          busy_q,      busy_d;

   logic          line_end;
   logic          last_line;
   logic [HW:0]   box_sum;
   logic [HW-1:0] box_wrap;
   logic [7:0]    pixel;

   function automatic int state_lines(state_t s);
      int n;
      n = 1;
      case (s)
         ST_VSYNC:  n = VSYNC_LINES;
         ST_VBACK:  n = V_BACK;
         ST_ACTIVE: n = IMG_VDISP;
         ST_VFRONT: n = V_FRONT;
         default:   n = 1;
      endcase
      return n;
   endfunction

   dvp_pattern_pixel #(
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP),
      .BOX_SIZE  (BOX_SIZE),
      .XW        (HW),
      .YW        (VW)
   ) u_pixel (
      .x     (h_cnt_q),
      .y     (v_cnt_q),
      .sel   (sel_q),
      .box_x (box_x_q),
      .flat  (flat_level),
      .pixel (pixel)
   );

   always_comb begin
      state_d     = state_q;
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      sel_d       = sel_q;
      box_x_d     = box_x_q;
      frame_cnt_d = frame_cnt_q;

      line_end  = (h_cnt_q == H_LAST);
      last_line = (int'(v_cnt_q) == state_lines(state_q) - 1);
      box_sum   = {1'b0, box_x_q} + (HW+1)'(BOX_STEP);
      box_wrap  = (int'(box_sum) > BOX_X_MAX) ? '0 : box_sum[HW-1:0];

      if (state_q == ST_IDLE) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
         if (enable) begin
            state_d = ST_VSYNC;
            sel_d   = pattern_t'(pattern_sel);
         end
      end else begin
         h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
         // Vertical state only moves on the last clock of a line.
         if (line_end) begin
            if (last_line) begin
               v_cnt_d = '0;
               case (state_q)
                  ST_VSYNC:  state_d = ST_VBACK;
                  ST_VBACK:  state_d = ST_ACTIVE;
                  ST_ACTIVE: state_d = ST_VFRONT;
                  default: begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                     box_x_d     = box_wrap;
                     if (enable) begin
                        state_d = ST_VSYNC;
                        sel_d   = pattern_t'(pattern_sel);
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               endcase
            end else begin
               v_cnt_d = v_cnt_q + VW'(1);
            end
         end
      end

      vsync_d = (state_q == ST_VSYNC);
      href_d  = (state_q == ST_ACTIVE) && (int'(h_cnt_q) < IMG_HDISP);
      data_d  = href_d ? pixel : 8'h00;
      busy_d  = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         sel_q       <= PAT_RAMP;
         box_x_q     <= '0;
         frame_cnt_q <= 8'h00;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         data_q      <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         sel_q       <= sel_d;
         box_x_q     <= box_x_d;
         frame_cnt_q <= frame_cnt_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
      end
   end

   assign cmos_vsync = vsync_q;
   assign cmos_href  = href_q;
   assign cmos_data  = data_q;
   assign frame_cnt  = frame_cnt_q;
   assign frame_busy = busy_q;

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Scoreboard bench for dvp_pattern_source on a 16x8 image: expected frames are
// queued at each vsync and popped by a monitor on every href-high clock.
module tb_dvp_pattern_source;

   localparam int IMG_HDISP   = 16;
   localparam int IMG_VDISP   = 8;
   localparam int H_BLANK     = 4;
   localparam int VSYNC_LINES = 1;
   localparam int V_BACK      = 2;
   localparam int V_FRONT     = 1;
   localparam int BOX_SIZE    = 4;
   localparam int BOX_STEP    = 4;
   localparam int H_TOTAL     = IMG_HDISP + H_BLANK;
   localparam int FRAME_CLKS  = H_TOTAL * (VSYNC_LINES + V_BACK + IMG_VDISP + V_FRONT);
   localparam int NF          = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic [7:0] flat_level = 8'h5A;
   logic       cmos_vsync;
   logic       cmos_href;
   logic [7:0] cmos_data;
   logic [7:0] frame_cnt;
   logic       frame_busy;

   always #5 clk = ~clk;

   dvp_pattern_source #(
      .IMG_HDISP   (IMG_HDISP),
      .IMG_VDISP   (IMG_VDISP),
      .H_BLANK     (H_BLANK),
      .VSYNC_LINES (VSYNC_LINES),
      .V_BACK      (V_BACK),
      .V_FRONT     (V_FRONT),
      .BOX_SIZE    (BOX_SIZE),
      .BOX_STEP    (BOX_STEP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .flat_level  (flat_level),
      .cmos_vsync  (cmos_vsync),
      .cmos_href   (cmos_href),
      .cmos_data   (cmos_data),
      .frame_cnt   (frame_cnt),
      .frame_busy  (frame_busy)
   );

   typedef struct {
      bit         is_flat;
      logic [7:0] val;
   } exp_t;

   exp_t       exp_q[$];
   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] flat_at_edge = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference image rules, straight from the pattern definitions.
   function automatic logic [7:0] ref_pixel(input int sel, input int x, input int y, input int bx);
      int y0;
      y0 = (IMG_VDISP - BOX_SIZE) / 2;
      case (sel)
         0:       return 8'((x + y) % 256);
         1:       return 8'(((x * 8) / IMG_HDISP) * 36);
         2:       return (x >= bx && x < bx + BOX_SIZE && y >= y0 && y < y0 + BOX_SIZE) ? 8'hF0 : 8'h20;
         default: return 8'h00;
      endcase
   endfunction

   function automatic int next_box(input int bx);
      int n;
      n = bx + BOX_STEP;
      return (n > IMG_HDISP - BOX_SIZE) ? 0 : n;
   endfunction

   function automatic int sel_for(input int f);
      if (f == 0) return 0;
      if (f <= 5) return 2;
      if (f == 6) return 1;
      if (f == 7) return 3;
      return int'($urandom_range(0, 3));
   endfunction

   task automatic push_frame(input int sel, input int bx);
      exp_t e;
      for (int y = 0; y < IMG_VDISP; y++) begin
         for (int x = 0; x < IMG_HDISP; x++) begin
            e.is_flat = (sel == 3);
            e.val     = ref_pixel(sel, x, y, bx);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_vsync_rise(input int limit, output bit ok);
      logic prev;
      prev = cmos_vsync;
      ok   = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         if (cmos_vsync && !prev) ok = 1'b1;
         prev = cmos_vsync;
      end
   endtask

   task automatic wait_href(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         if (cmos_href) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         if (!frame_busy) ok = 1'b1;
      end
   endtask

   // flat_level as the DUT saw it at the most recent rising edge.
   initial forever begin
      @(posedge clk);
      flat_at_edge = flat_level;
   end

   // Monitor: scoreboard pops plus frame/line timing measurements.
   initial begin
      logic prev_vs, prev_hr, fall_seen;
      int   vs_len, since_fall, hr_len, gap, pulses;
      exp_t e;
      int   expv;
      prev_vs = 0; prev_hr = 0; fall_seen = 0;
      vs_len = 0; since_fall = 0; hr_len = 0; gap = 0; pulses = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_vs = 0; prev_hr = 0; fall_seen = 0;
            vs_len = 0; since_fall = 0; hr_len = 0; gap = 0; pulses = 0;
         end else begin
            if (cmos_vsync) begin
               if (!prev_vs) begin
                  if (pulses > 0) check("href_pulses_per_frame", pulses, IMG_VDISP);
                  pulses    = 0;
                  fall_seen = 0;
                  vs_len    = 0;
               end
               vs_len++;
            end else if (prev_vs) begin
               check("vsync_len", vs_len, VSYNC_LINES * H_TOTAL);
               fall_seen  = 1;
               since_fall = 0;
            end else begin
               since_fall++;
            end

            if (cmos_href) begin
               if (!prev_hr) begin
                  if (pulses == 0) begin
                     if (fall_seen) check("vsync_fall_to_href", since_fall, V_BACK * H_TOTAL);
                  end else begin
                     check("href_gap", gap, H_BLANK);
                  end
                  pulses++;
                  hr_len = 0;
               end
               hr_len++;
               if (exp_q.size() == 0) begin
                  check("sb_unexpected_pixel", int'(cmos_data), -1);
               end else begin
                  e    = exp_q.pop_front();
                  expv = e.is_flat ? int'(flat_at_edge) : int'(e.val);
                  check("pixel", int'(cmos_data), expv);
               end
            end else begin
               if (prev_hr) begin
                  check("href_len", hr_len, IMG_HDISP);
                  gap = 1;
               end else begin
                  gap++;
               end
               check("data_zero_href_low", int'(cmos_data), 0);
            end
            prev_vs = cmos_vsync;
            prev_hr = cmos_href;
         end
      end
   end

   initial begin
      bit ok;
      int bx, frames_done, cur_sel, busy_hits;
      bx = 0;
      frames_done = 0;

      repeat (5) @(negedge clk);
      check("rst_vsync", int'(cmos_vsync), 0);
      check("rst_href", int'(cmos_href), 0);
      check("rst_data", int'(cmos_data), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      check("rst_busy", int'(frame_busy), 0);

      cur_sel     = sel_for(0);
      pattern_sel = 2'(cur_sel);
      enable      = 1'b1;
      rst_n       = 1'b1;

      for (int f = 0; f < NF; f++) begin
         wait_vsync_rise(2 * FRAME_CLKS, ok);
         if (!ok) begin
            check("timeout_vsync_rise", 0, 1);
            break;
         end
         check("frame_cnt_at_vsync", int'(frame_cnt), frames_done % 256);
         $display("frame %0d: sel %0d box_x %0d frame_cnt %0d", f, cur_sel, bx, frame_cnt);
         push_frame(cur_sel, bx);
         wait_href(FRAME_CLKS, ok);
         if (!ok) begin
            check("timeout_href", 0, 1);
            break;
         end
         // Mid-frame: random flat changes, then next-frame select or stop.
         repeat ($urandom_range(1, 60)) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) flat_level = 8'($urandom);
         end
         if (f == NF - 1) begin
            enable = 1'b0;
         end else begin
            cur_sel     = sel_for(f + 1);
            pattern_sel = 2'(cur_sel);
         end
         frames_done++;
         bx = next_box(bx);
      end

      wait_idle(2 * FRAME_CLKS, ok);
      check("busy_fall_after_stop", int'(ok), 1);
      check("frame_cnt_after_stop", int'(frame_cnt), frames_done % 256);
      check("sb_empty_after_stop", exp_q.size(), 0);
      busy_hits = 0;
      repeat (30) begin
         @(negedge clk);
         if (cmos_vsync || cmos_href || frame_busy || cmos_data != 8'h00) busy_hits++;
      end
      check("idle_outputs_quiet", busy_hits, 0);
      $display("stopped: frame_cnt %0d", frame_cnt);

      cur_sel     = 2;
      pattern_sel = 2'd2;
      enable      = 1'b1;
      @(negedge clk);
      check("vsync_low_at_enable_edge", int'(cmos_vsync), 0);
      @(negedge clk);
      check("vsync_after_reenable", int'(cmos_vsync), 1);
      check("frame_cnt_at_reenable", int'(frame_cnt), frames_done % 256);
      $display("frame re-enable: sel %0d box_x %0d", cur_sel, bx);
      push_frame(cur_sel, bx);

      wait_href(FRAME_CLKS, ok);
      check("href_after_reenable", int'(ok), 1);
      repeat ($urandom_range(3, 40)) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_href", int'(cmos_href), 0);
      check("midrst_vsync", int'(cmos_vsync), 0);
      check("midrst_data", int'(cmos_data), 0);
      check("midrst_busy", int'(frame_busy), 0);
      check("midrst_frame_cnt", int'(frame_cnt), 0);
      exp_q.delete();
      frames_done = 0;
      bx = 0;
      repeat (3) @(negedge clk);

      cur_sel     = 2;
      pattern_sel = 2'd2;
      rst_n       = 1'b1;
      wait_vsync_rise(2 * FRAME_CLKS, ok);
      check("vsync_after_midrst", int'(ok), 1);
      check("frame_cnt_after_midrst", int'(frame_cnt), 0);
      $display("frame after reset: sel %0d box_x %0d", cur_sel, bx);
      push_frame(cur_sel, bx);
      wait_href(FRAME_CLKS, ok);
      check("href_after_midrst", int'(ok), 1);
      enable = 1'b0;
      pattern_sel = 2'd0;
      frames_done++;
      wait_idle(2 * FRAME_CLKS, ok);
      check("busy_fall_final", int'(ok), 1);
      check("frame_cnt_final", int'(frame_cnt), frames_done);
      check("sb_empty_final", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
